// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared constants, state encoding and key-code helper for the
//             4x4 keypad matrix scanner.
//  Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int         ROWS     = 4;
    localparam int         COLS     = 4;
    localparam logic [3:0] ROW_IDLE = 4'b1111;

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;

    function automatic logic [3:0] encode_key(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : scan_tick_gen
//  Purpose  : Free-running divider producing a one-clk scan tick every
//             CLK_DIV clocks; shared with the dot-matrix display driver.
//  Revision : 1.0 - initial release
// ============================================================================
module scan_tick_gen #(
    parameter int CLK_DIV = 2500
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (r_div == c_DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

    assign tick = (r_div == c_DIV_LAST);

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_matrix_scanner
//  Purpose  : Scans a 4x4 active-low key matrix one row at a time, debounces
//             a single key and reports it as code = row*4 + col.
//  Options  : KEYPAD_REPEAT_EN - auto-repeat key_valid pulses while held.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV        = 2500,
    parameter int DEBOUNCE_TICKS = 8,
    parameter int REPEAT_DELAY   = 400,
    parameter int REPEAT_RATE    = 100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [COLS-1:0] col_input,
    output logic [ROWS-1:0] row_select,
    output logic [3:0]      key_code,
    output logic            key_valid,
    output logic            key_pressed
);

    localparam int                 c_CNT_W  = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [c_CNT_W-1:0] c_DB_MAX = c_CNT_W'(DEBOUNCE_TICKS);

    logic                w_tick;
    logic [COLS-1:0]     r_sync1;
    logic [COLS-1:0]     r_sync2;
    logic [1:0]          r_state;
    logic [1:0]          r_row;
    logic [1:0]          r_col;
    logic [COLS-1:0]     r_pattern;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  r_rel_cnt;
    logic [ROWS-1:0]     r_row_select;
    logic [3:0]          r_key_code;
    logic                r_key_valid;
    logic                r_key_pressed;
    logic                w_one_low;
    logic [1:0]          w_col_idx;

`ifdef KEYPAD_REPEAT_EN
    localparam int                 c_REP_W      = $clog2(REPEAT_DELAY + 1);
    localparam logic [c_REP_W-1:0] c_REP_DELAY  = c_REP_W'(REPEAT_DELAY);
    localparam logic [c_REP_W-1:0] c_REP_RELOAD = c_REP_W'(REPEAT_DELAY - REPEAT_RATE);

    logic [c_REP_W-1:0] r_rep_cnt;
`else
    logic [31:0] w_unused_repeat_cfg;
    assign w_unused_repeat_cfg = REPEAT_DELAY ^ REPEAT_RATE;
`endif

    scan_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    // Only a single low column is a usable key; ghosts and idle both fall through.
    always_comb begin
        w_one_low = 1'b0;
        w_col_idx = 2'd0;
        case (r_sync2)
            4'b1110: begin w_one_low = 1'b1; w_col_idx = 2'd0; end
            4'b1101: begin w_one_low = 1'b1; w_col_idx = 2'd1; end
            4'b1011: begin w_one_low = 1'b1; w_col_idx = 2'd2; end
            4'b0111: begin w_one_low = 1'b1; w_col_idx = 2'd3; end
            default: ;
        endcase
    end

    // Threshold actions fire on the clk after the tick that reaches them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1       <= '1;
            r_sync2       <= '1;
            r_state       <= SCAN;
            r_row         <= 2'd0;
            r_col         <= 2'd0;
            r_pattern     <= '1;
            r_cnt         <= '0;
            r_rel_cnt     <= '0;
            r_row_select  <= ROW_IDLE;
            r_key_code    <= 4'd0;
            r_key_valid   <= 1'b0;
            r_key_pressed <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt     <= '0;
`endif
        end else begin
            r_sync1      <= col_input;
            r_sync2      <= r_sync1;
            r_row_select <= ~(ROWS'(1) << r_row);
            r_key_valid  <= 1'b0;

            case (r_state)
                SCAN: begin
                    if (w_tick) begin
                        if (w_one_low) begin
                            r_col     <= w_col_idx;
                            r_pattern <= r_sync2;
                            r_cnt     <= '0;
                            r_state   <= DEBOUNCE;
                        end else begin
                            r_row <= r_row + 2'd1;
                        end
                    end
                end

                DEBOUNCE: begin
                    if (r_cnt == c_DB_MAX) begin
                        r_key_code    <= encode_key(r_row, r_col);
                        r_key_valid   <= 1'b1;
                        r_key_pressed <= 1'b1;
                        r_rel_cnt     <= '0;
                        r_state       <= HELD;
`ifdef KEYPAD_REPEAT_EN
                        r_rep_cnt     <= '0;
`endif
                    end else if (w_tick) begin
                        if (r_sync2 == r_pattern) begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end else begin
                            r_row   <= r_row + 2'd1;
                            r_state <= SCAN;
                        end
                    end
                end

                HELD: begin
                    if (r_rel_cnt == c_DB_MAX) begin
                        r_key_pressed <= 1'b0;
                        r_row         <= r_row + 2'd1;
                        r_state       <= SCAN;
`ifdef KEYPAD_REPEAT_EN
                        r_rep_cnt     <= '0;
`endif
                    end else begin
                        if (w_tick) begin
                            r_rel_cnt <= (&r_sync2) ? r_rel_cnt + c_CNT_W'(1) : '0;
                        end
`ifdef KEYPAD_REPEAT_EN
                        if (r_rep_cnt == c_REP_DELAY) begin
                            r_key_valid <= 1'b1;
                            r_rep_cnt   <= c_REP_RELOAD;
                        end else if (w_tick) begin
                            r_rep_cnt <= r_rep_cnt + c_REP_W'(1);
                        end
`endif
                    end
                end

                default: r_state <= SCAN;
            endcase
        end
    end

    assign row_select  = r_row_select;
    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_pressed = r_key_pressed;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_matrix_scanner
//  Purpose  : Directed self-checking bench for keypad_matrix_scanner with a
//             key-matrix model and a scoreboard of expected key_valid pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_scanner;

    typedef struct {
        logic [3:0] code;
        int         cycle;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col_input;
    logic [3:0]  row_select;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_pressed;

    logic [15:0] keys_down = 16'h0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;
    exp_t        sb_q[$];
    exp_t        mon_e;

    always #5 clk = ~clk;

    keypad_matrix_scanner #(
        .CLK_DIV        (4),
        .DEBOUNCE_TICKS (3),
        .REPEAT_DELAY   (6),
        .REPEAT_RATE    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .col_input   (col_input),
        .row_select  (row_select),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_pressed (key_pressed)
    );

    // Pulled-up columns pulled low by any held key on a driven row.
    always_comb begin
        col_input = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys_down[r*4+c] && !row_select[r]) col_input[c] = 1'b0;
            end
        end
    end

    // Cycle index relative to the last clock edge with reset asserted.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            pulses++;
            checks++;
            assert (sb_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_pulse: key_valid=1 code=%0d at cyc %0d, required no pulse", key_code, cyc);
            end
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                checks++;
                assert (key_code === mon_e.code) else begin
                    errors++;
                    $error("FAIL pulse_code: observed=%0d expected=%0d", key_code, mon_e.code);
                end
                checks++;
                assert (cyc === mon_e.cycle) else begin
                    errors++;
                    $error("FAIL pulse_cycle: observed=%0d expected=%0d", cyc, mon_e.cycle);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [3:0] code, input int cycle);
        exp_t e;
        e.code  = code;
        e.cycle = cycle;
        sb_q.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;

        // Idle scan after a 5-clk reset
        keys_down = 16'h0;
        do_reset(5);
        check("rst_row_select", row_select, 32'hF);
        check("rst_key_code", key_code, 32'h0);
        check("rst_key_valid", key_valid, 32'h0);
        check("rst_key_pressed", key_pressed, 32'h0);
        wait_cyc(1);  check("scan_row0", row_select, 32'hE);
        wait_cyc(5);  check("scan_row1", row_select, 32'hD);
        wait_cyc(9);  check("scan_row2", row_select, 32'hB);
        wait_cyc(13); check("scan_row3", row_select, 32'h7);
        wait_cyc(17); check("scan_wrap", row_select, 32'hE);
        wait_cyc(20);

        // Key 9 held steady, released right after acceptance
        keys_down = 16'h0200;
        do_reset(2);
        push_exp(4'd9, 25);
        wait_cyc(26);
        check("k9_code", key_code, 32'd9);
        check("k9_pressed", key_pressed, 32'd1);
        keys_down = 16'h0;
        wait_cyc(40); check("k9_still_pressed", key_pressed, 32'd1);
        wait_cyc(41); check("k9_released", key_pressed, 32'd0);
        check("k9_code_holds", key_code, 32'd9);
        wait_cyc(42); check("k9_next_row", row_select, 32'h7);
        check("k9_sb_empty", sb_q.size(), 32'd0);

        // Key 3 bouncing on alternate ticks for 10 ticks, then stable
        keys_down = 16'h0008;
        do_reset(2);
        for (int k = 1; k <= 10; k++) begin
            wait_cyc(4*k + 1);
            keys_down[3] = (k % 2 == 0);
        end
        push_exp(4'd3, 69);
        wait_cyc(72);
        check("k3_code", key_code, 32'd3);
        check("k3_pressed", key_pressed, 32'd1);
        check("k3_sb_empty", sb_q.size(), 32'd0);

        // Ambiguous pattern on row 1 (keys 4 and 6)
        keys_down = 16'h0050;
        do_reset(2);
        wait_cyc(6); check("amb_row1", row_select, 32'hD);
        wait_cyc(8); check("amb_row1_hold", row_select, 32'hD);
        wait_cyc(9); check("amb_row2", row_select, 32'hB);
        wait_cyc(40);
        check("amb_not_pressed", key_pressed, 32'd0);

        // Reset while key 5 is held, then re-detect from row 0
        keys_down = 16'h0020;
        do_reset(2);
        push_exp(4'd5, 21);
        wait_cyc(24);
        check("k5_pressed", key_pressed, 32'd1);
        check("k5_code", key_code, 32'd5);
        do_reset(1);
        check("midrst_row_select", row_select, 32'hF);
        check("midrst_pressed", key_pressed, 32'd0);
        check("midrst_code", key_code, 32'd0);
        check("midrst_valid", key_valid, 32'd0);
        wait_cyc(1);
        check("midrst_valid_next", key_valid, 32'd0);
        check("midrst_row0", row_select, 32'hE);
        push_exp(4'd5, 21);
        wait_cyc(24);
        check("k5_redetect_pressed", key_pressed, 32'd1);
        check("k5_sb_empty", sb_q.size(), 32'd0);

        // Key 15 held for 12 ticks after acceptance
        keys_down = 16'h8000;
        do_reset(2);
        p0 = pulses;
        push_exp(4'd15, 29);
`ifdef KEYPAD_REPEAT_EN
        push_exp(4'd15, 53);
        push_exp(4'd15, 61);
        push_exp(4'd15, 69);
        push_exp(4'd15, 77);
`endif
        wait_cyc(80);
`ifdef KEYPAD_REPEAT_EN
        check("k15_pulse_count", pulses - p0, 32'd5);
`else
        check("k15_pulse_count", pulses - p0, 32'd1);
`endif
        check("k15_pressed", key_pressed, 32'd1);
        check("k15_sb_empty", sb_q.size(), 32'd0);
        keys_down = 16'h0;
        do_reset(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
